led_pattern_ctrl: RTL
=====================

// Module: led_pattern_ctrl
// PURPOSE
//   Sequencer for the board LED bank. Generates its own step tick from clk and drives an
//   8-bit LED pattern. Two push-buttons select the pattern mode and the step speed, and a
//   pause input freezes the display. It replaces the free-running divider/counter pair as
//   the LED top-level controller.
// PARAMETERS
//   LED_W      8         LED bank width (BEHAVIOUR values below assume 8)
//   BASE_DIV   25000000  clk cycles per step at speed 0; must be a multiple of 8
//   DB_CYCLES  500000    clk cycles a synchronized button level must be stable to be accepted
// PORTS
//   clk        in   1      system clock; all logic on posedge clk
//   rst        in   1      asynchronous, active-low reset
//   btn_mode   in   1      raw mode button, asynchronous, active-high
//   btn_speed  in   1      raw speed button, asynchronous, active-high
//   pause      in   1      synchronous level; 1 = freeze pattern and prescaler
//   led        out  LED_W  LED pattern, registered
//   mode       out  2      current mode: 0 UP, 1 DN, 2 SHIFT, 3 BLINK
//   speed      out  2      current speed select 0..3
//   tick       out  1      one-cycle pulse on each pattern step
// BEHAVIOUR
//   Reset (rst=0, asynchronous): led=8'h00, mode=UP, speed=0, tick=0, shift dir=left,
//     prescaler=0, debouncers idle and their outputs low.
//   Buttons:
//     - 2-flop synchronizer, then debounce: the accepted level changes only after
//       DB_CYCLES consecutive equal samples.
//     - A rising edge of the accepted level gives a one-cycle press pulse.
//     - Latency from a raw edge to the mode/speed change: DB_CYCLES+3 to DB_CYCLES+4 clks.
//     - Glitches shorter than DB_CYCLES produce no pulse.
//   Prescaler:
//     - Counts 0..LIMIT-1, with LIMIT = BASE_DIV >> speed (speed 0..3 -> /1,/2,/4,/8).
//     - tick=1 in the cycle after the count reaches LIMIT-1; the count then wraps to 0.
//     - While pause=1 the count holds and tick=0.
//   Mode press: mode advances UP->DN->SHIFT->BLINK->UP (wraps).
//     - On the same edge: prescaler cleared, led loaded with the new mode's initial value
//       (UP 8'h00, DN 8'hFF, SHIFT 8'h01 with dir=left, BLINK 8'h00).
//     - Applies even while pause=1.
//   Speed press: speed = speed+1 mod 4 (3->0); prescaler cleared; led unchanged.
//   Step rules on tick:
//     - UP:    led+1, wraps 8'hFF->8'h00.
//     - DN:    led-1, wraps 8'h00->8'hFF.
//     - SHIFT: one lit bit, shifted one place per tick. dir=left shifts toward the MSB;
//       at 8'h80 dir flips and the next step is 8'h40. At 8'h01 moving right, dir flips
//       and the next step is 8'h02. Sequence: 01,02,..,80,40,..,01,02.
//     - BLINK: led = ~led (00 <-> FF).
//   Priority in one cycle: reset > mode press > speed press > tick step.
//     - A tick landing in a mode-press cycle is discarded; led takes the initial value.
//     - Simultaneous mode and speed presses: both updates apply, led reloads once.
//   Reset mid-operation: all state returns to reset values at once; no pending press survives.
// STRUCTURE
//   Package led_ctrl_pkg: mode encoding constants (MODE_UP..MODE_BLINK), per-mode initial
//     LED values, speed width.
//   Sub-module btn_debounce (synchronizer + debounce counter + edge pulse), instantiated
//     once per button.
//   Top level holds: prescaler, mode/speed registers, pattern register, shift direction flag.
// TESTING  (bench parameters BASE_DIV=8, DB_CYCLES=4)
//   1 Release reset, pause=0 -> led=00, mode=0; tick every 8 clks; led 01,02,..; after 256
//     ticks led=00 again.
//   2 Hold btn_mode 10 clks -> within 8 clks of the press: mode=1, led=FF; next ticks FE,FD.
//   3 Two more mode presses -> mode=2, led=01; ticks give 02,04,..,80,40,20,..,01,02.
//   4 btn_mode pulses 2 clks high, repeated at 3-clk gaps -> no press pulse, mode unchanged.
//   5 btn_speed presses x3 -> tick period 4,2,1 clks; 4th press -> period 8. pause=1 for
//     20 clks -> tick=0 and led frozen; resume -> next tick 8 clks after release.
//   6 Mode press timed onto a tick cycle -> led=new initial value, not stepped. Drop rst
//     mid-count -> led=00, mode=0, speed=0 in the same cycle, before the next clk edge.

Source files
------------

// File: rtl/led_pattern_ctrl_pkg.sv
// Shared definitions for the LED pattern controller.
//   mode_t    : pattern mode encoding (UP, DN, SHIFT, BLINK)
//   SPD_W     : width of the speed select
//   LED_INIT_*: LED value loaded when a mode is entered
//   mode_init : maps a mode to its initial LED value
package led_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_UP    = 2'd0,
    MODE_DN    = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  localparam int SPD_W = 2;

  localparam logic [7:0] LED_INIT_UP    = 8'h00;
  localparam logic [7:0] LED_INIT_DN    = 8'hFF;
  localparam logic [7:0] LED_INIT_SHIFT = 8'h01;
  localparam logic [7:0] LED_INIT_BLINK = 8'h00;

  function automatic logic [7:0] mode_init(mode_t m);
    case (m)
      MODE_UP:    return LED_INIT_UP;
      MODE_DN:    return LED_INIT_DN;
      MODE_SHIFT: return LED_INIT_SHIFT;
      default:    return LED_INIT_BLINK;
    endcase
  endfunction
endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Board-facing signal bundle of the LED pattern controller.
//   btn_mode, btn_speed : raw push-buttons (asynchronous, active-high)
//   pause               : synchronous freeze level
//   led, mode, speed    : registered pattern / status outputs
//   tick                : one-cycle step pulse
// master = board/stimulus side, slave = controller side.
interface led_pattern_ctrl_if #(parameter int LED_W = 8);
  import led_ctrl_pkg::*;

  logic             btn_mode;
  logic             btn_speed;
  logic             pause;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;
  logic [SPD_W-1:0] speed;
  logic             tick;

  modport master (output btn_mode, btn_speed, pause,
                  input  led, mode, speed, tick);
  modport slave  (input  btn_mode, btn_speed, pause,
                  output led, mode, speed, tick);
endinterface

// File: rtl/led_pattern_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and
// rising-edge press pulse.
//   clk, rst : clock, asynchronous active-low reset
//   btn      : raw asynchronous button level
//   press    : one-cycle pulse on each accepted press (registered)
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1, s2;
  logic          db, db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      db_q  <= db;
      press <= db & ~db_q;
      // cnt counts consecutive samples disagreeing with the accepted level;
      // any agreeing sample restarts the run.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: internal step prescaler, mode/speed selection from two
// debounced buttons, pause, and UP/DN/SHIFT/BLINK pattern generation.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : led_pattern_ctrl_if.slave (buttons, pause, led, mode, speed, tick)
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int LED_W     = 8,
  parameter int BASE_DIV  = 25000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_ctrl_if.slave bus
);
  localparam int CW = $clog2(BASE_DIV);

  // press[0] = mode button, press[1] = speed button
  logic [1:0] btn_raw, press;
  assign btn_raw = {bus.btn_speed, bus.btn_mode};

  for (genvar i = 0; i < 2; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[i]),
      .press (press[i])
    );
  end

  mode_t            mode_q, mode_d, mode_nx;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             dir_q, dir_d;    // 0 = toward MSB, 1 = toward LSB
  logic [CW-1:0]    cnt_q, cnt_d, lim_m1;
  logic             tick_q, tick_d;

  assign mode_nx = mode_t'(mode_q + 2'd1);
  assign lim_m1  = CW'((BASE_DIV >> speed_q) - 1);

  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    led_d   = led_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (press[0]) begin
      // Mode press wins over any step landing in the same cycle.
      mode_d = mode_nx;
      led_d  = LED_W'(mode_init(mode_nx));
      dir_d  = 1'b0;
      cnt_d  = '0;
      if (press[1]) speed_d = speed_q + 1'b1;
    end else if (press[1]) begin
      speed_d = speed_q + 1'b1;
      cnt_d   = '0;
    end else if (!bus.pause) begin
      if (cnt_q == lim_m1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        unique case (mode_q)
          MODE_UP: led_d = led_q + 1'b1;
          MODE_DN: led_d = led_q - 1'b1;
          MODE_SHIFT: begin
            // Bounce at the ends: reversing at an end steps straight back in.
            if (!dir_q) begin
              if (led_q[LED_W-1]) begin
                led_d = led_q >> 1;
                dir_d = 1'b1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d = led_q << 1;
                dir_d = 1'b0;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          default: led_d = ~led_q;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_UP;
      speed_q <= '0;
      led_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      speed_q <= speed_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.mode  = mode_q;
  assign bus.speed = speed_q;
  assign bus.tick  = tick_q;
endmodule
